// File: rtl/reg_file_pkg.sv
// Shared widths, sizes and state encoding for the register-file dump reader.
package reg_file_pkg;

   localparam int DATA_WIDTH = 8;
   localparam int ADDR_WIDTH = 3;
   localparam int NUM_REGS   = 8;
   localparam int K_WIDTH    = ADDR_WIDTH - 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      SEND0 = 3'd2,
      SEND1 = 3'd3,
      FIN   = 3'd4
   } state_t;

   // Concatenation rather than 2k+1 arithmetic, so the top pair never wraps.
   function automatic logic [ADDR_WIDTH-1:0] pair_addr(input logic [K_WIDTH-1:0] k,
                                                      input logic odd);
      return {k, odd};
   endfunction

endpackage

// File: rtl/reg_file_reader_if.sv
// Register-file read ports plus the valid/ready dump stream of the reader.
interface reg_file_reader_if;
   import reg_file_pkg::*;

   logic [ADDR_WIDTH-1:0] READREG1;
   logic [ADDR_WIDTH-1:0] READREG2;
   logic [DATA_WIDTH-1:0] REGOUT1;
   logic [DATA_WIDTH-1:0] REGOUT2;
   logic [DATA_WIDTH-1:0] DUMPDATA;
   logic [ADDR_WIDTH-1:0] DUMPADDR;
   logic                  DUMPVALID;
   logic                  DUMPREADY;

   modport master (
      output READREG1, READREG2, DUMPDATA, DUMPADDR, DUMPVALID,
      input  REGOUT1, REGOUT2, DUMPREADY
   );

   modport slave (
      input  READREG1, READREG2, DUMPDATA, DUMPADDR, DUMPVALID,
      output REGOUT1, REGOUT2, DUMPREADY
   );

endinterface

// File: rtl/reg_dump_pair_buf.sv
// Two-entry capture buffer: loads a register pair in one edge and presents
// the even entry first, then the odd entry when told to advance.
module reg_dump_pair_buf
   import reg_file_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_load,
   input  logic                  i_sel_hi,
   input  logic [DATA_WIDTH-1:0] i_d0,
   input  logic [DATA_WIDTH-1:0] i_d1,
   output logic [DATA_WIDTH-1:0] o_data
);

   logic [DATA_WIDTH-1:0] r_buf0;
   logic [DATA_WIDTH-1:0] r_buf1;
   logic [DATA_WIDTH-1:0] r_data;

   // Pair capture and registered output selection.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_buf0 <= '0;
         r_buf1 <= '0;
         r_data <= '0;
      end else if (i_load) begin
         r_buf0 <= i_d0;
         r_buf1 <= i_d1;
         r_data <= i_d0;
      end else if (i_sel_hi) begin
         r_data <= r_buf1;
      end else begin
         r_data <= r_data;
      end
   end

   assign o_data = r_data;

endmodule

// File: rtl/reg_file_reader.sv
// Dump sequencer: reads the register file two entries at a time and streams
// every value with its index over a valid/ready channel.
module reg_file_reader
   import reg_file_pkg::*;
(
   input  logic              CLK,
   input  logic              RESET,
   input  logic              START,
   input  logic              ABORT,
   reg_file_reader_if.master bus,
   output logic              BUSY,
   output logic              DONE
);

   localparam logic [K_WIDTH-1:0] LAST_K = K_WIDTH'(NUM_REGS / 2 - 1);

   state_t                r_state;
   state_t                w_state_next;
   logic [K_WIDTH-1:0]    r_k;
   logic [K_WIDTH-1:0]    w_k_next;
   logic                  w_hs;
   logic                  w_load;
   logic                  w_sel_hi;
   logic [ADDR_WIDTH-1:0] r_readreg1;
   logic [ADDR_WIDTH-1:0] r_readreg2;
   logic [ADDR_WIDTH-1:0] r_dump_addr;
   logic                  r_valid;
   logic                  r_busy;
   logic                  r_done;
   logic [DATA_WIDTH-1:0] w_dump_data;

   assign w_hs = r_valid & bus.DUMPREADY;

   // Next state and pair counter; ABORT outranks handshake and START.
   always_comb begin
      w_state_next = r_state;
      w_k_next     = r_k;
      if (ABORT && (r_state != IDLE)) begin
         w_state_next = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (START) begin
                  w_state_next = SETUP;
                  w_k_next     = '0;
               end else begin
                  w_state_next = IDLE;
               end
            end
            SETUP: w_state_next = SEND0;
            SEND0: begin
               if (w_hs) begin
                  w_state_next = SEND1;
               end else begin
                  w_state_next = SEND0;
               end
            end
            SEND1: begin
               if (w_hs && (r_k == LAST_K)) begin
                  w_state_next = FIN;
               end else if (w_hs) begin
                  w_state_next = SETUP;
                  w_k_next     = r_k + K_WIDTH'(1);
               end else begin
                  w_state_next = SEND1;
               end
            end
            FIN:     w_state_next = IDLE;
            default: w_state_next = IDLE;
         endcase
      end
   end

   assign w_load   = (r_state == SETUP) && (w_state_next == SEND0);
   assign w_sel_hi = (r_state == SEND0) && (w_state_next == SEND1);

   // State and pair counter registers.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_state <= IDLE;
         r_k     <= '0;
      end else begin
         r_state <= w_state_next;
         r_k     <= w_k_next;
      end
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         r_valid     <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_readreg1  <= '0;
         r_readreg2  <= '0;
         r_dump_addr <= '0;
      end else begin
         r_valid <= (w_state_next == SEND0) || (w_state_next == SEND1);
         r_busy  <= (w_state_next != IDLE);
         r_done  <= (w_state_next == FIN);
         if (w_state_next == IDLE) begin
            r_readreg1 <= '0;
            r_readreg2 <= '0;
         end else if ((w_state_next == SETUP) && (r_state != SETUP)) begin
            r_readreg1 <= pair_addr(w_k_next, 1'b0);
            r_readreg2 <= pair_addr(w_k_next, 1'b1);
         end else begin
            r_readreg1 <= r_readreg1;
            r_readreg2 <= r_readreg2;
         end
         if (w_load) begin
            r_dump_addr <= pair_addr(r_k, 1'b0);
         end else if (w_sel_hi) begin
            r_dump_addr <= pair_addr(r_k, 1'b1);
         end else begin
            r_dump_addr <= r_dump_addr;
         end
      end
   end

   reg_dump_pair_buf u_pair_buf (
      .i_clk    (CLK),
      .i_rst_n  (RESET),
      .i_load   (w_load),
      .i_sel_hi (w_sel_hi),
      .i_d0     (bus.REGOUT1),
      .i_d1     (bus.REGOUT2),
      .o_data   (w_dump_data)
   );

   assign bus.READREG1  = r_readreg1;
   assign bus.READREG2  = r_readreg2;
   assign bus.DUMPDATA  = w_dump_data;
   assign bus.DUMPADDR  = r_dump_addr;
   assign bus.DUMPVALID = r_valid;
   assign BUSY          = r_busy;
   assign DONE          = r_done;

endmodule

// File: tb/tb_reg_file_reader.sv
// Directed bench for reg_file_reader with a behavioural 8x8 register file.
module tb_reg_file_reader;
   import reg_file_pkg::*;

   logic CLK   = 1'b0;
   logic RESET = 1'b0;
   logic START = 1'b0;
   logic ABORT = 1'b0;
   logic BUSY;
   logic DONE;

   reg_file_reader_if bus();

   logic [7:0] rf [0:7];
   int checks    = 0;
   int errors    = 0;
   int cyc       = 0;
   int done_cnt  = 0;
   int done_edge = 0;
   logic [2:0] b_addr [$];
   logic [7:0] b_data [$];
   int         b_edge [$];

   always #5 CLK = ~CLK;

   assign bus.REGOUT1 = rf[bus.READREG1];
   assign bus.REGOUT2 = rf[bus.READREG2];

   reg_file_reader dut (
      .CLK   (CLK),
      .RESET (RESET),
      .START (START),
      .ABORT (ABORT),
      .bus   (bus.master),
      .BUSY  (BUSY),
      .DONE  (DONE)
   );

   always @(posedge CLK) cyc <= cyc + 1;

   // Beats are logged at the negedge before the edge that transfers them.
   always @(negedge CLK) begin
      if (RESET && bus.DUMPVALID && bus.DUMPREADY && !ABORT) begin
         b_addr.push_back(bus.DUMPADDR);
         b_data.push_back(bus.DUMPDATA);
         b_edge.push_back(cyc + 1);
      end
      if (RESET && DONE) begin
         done_cnt  <= done_cnt + 1;
         done_edge <= cyc + 1;
      end
   end

   task automatic start_pulse(output int t);
      @(posedge CLK); #1 START = 1'b1;
      @(negedge CLK); t = cyc + 1;
      @(posedge CLK); #1 START = 1'b0;
   endtask

   task automatic wait_addr(input logic [2:0] a, output bit found);
      found = 1'b0;
      for (int n = 0; n < 60 && !found; n++) begin
         @(negedge CLK);
         if (bus.DUMPVALID && bus.DUMPADDR == a) found = 1'b1;
      end
   endtask

   task automatic wait_done(input int dbase, output bit found);
      found = 1'b0;
      for (int n = 0; n < 60 && !found; n++) begin
         @(negedge CLK);
         if (done_cnt > dbase) found = 1'b1;
      end
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({bus.READREG1, bus.READREG2, bus.DUMPDATA, bus.DUMPADDR, bus.DUMPVALID, BUSY, DONE} !== 20'd0) begin
         errors++;
         $display("FAIL reset_outputs got rr1=%0h rr2=%0h d=%0h a=%0h v=%0b b=%0b dn=%0b exp all 0",
                  bus.READREG1, bus.READREG2, bus.DUMPDATA, bus.DUMPADDR, bus.DUMPVALID, BUSY, DONE);
      end
      @(posedge CLK); #1 RESET = 1'b1;
      repeat (3) @(negedge CLK);
      checks++;
      if (BUSY !== 1'b0 || bus.DUMPVALID !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset got busy=%0b valid=%0b exp 0 0", BUSY, bus.DUMPVALID);
      end
   endtask

   task automatic test_full_dump();
      int t, base, dbase, guard;
      int offs [8];
      bit found;
      offs  = '{2, 3, 5, 6, 8, 9, 11, 12};
      base  = b_addr.size();
      dbase = done_cnt;
      start_pulse(t);
      wait_done(dbase, found);
      checks++;
      if (!found) begin errors++; $display("FAIL full_done_timeout got none exp DONE"); end
      guard = 0;
      while (cyc < t + 13 && guard < 60) begin @(negedge CLK); guard++; end
      checks++;
      if (BUSY !== 1'b0) begin errors++; $display("FAIL full_busy_t14 got %0b exp 0", BUSY); end
      checks++;
      if (done_edge != t + 13) begin errors++; $display("FAIL full_done_time got t+%0d exp t+13", done_edge - t); end
      checks++;
      if (done_cnt - dbase != 1) begin errors++; $display("FAIL full_done_count got %0d exp 1", done_cnt - dbase); end
      checks++;
      if (b_addr.size() - base != 8) begin errors++; $display("FAIL full_beats got %0d exp 8", b_addr.size() - base); end
      for (int i = 0; i < 8; i++) begin
         if (base + i < b_addr.size()) begin
            checks++;
            if (b_addr[base+i] !== 3'(i) || b_data[base+i] !== 8'(8'h10 + i)) begin
               errors++;
               $display("FAIL full_beat%0d got a=%0d d=%0h exp a=%0d d=%0h", i, b_addr[base+i], b_data[base+i], i, 8'h10 + i);
            end
            checks++;
            if (b_edge[base+i] - t != offs[i]) begin
               errors++;
               $display("FAIL full_time%0d got t+%0d exp t+%0d", i, b_edge[base+i] - t, offs[i]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int t, base, dbase;
      bit found;
      base  = b_addr.size();
      dbase = done_cnt;
      start_pulse(t);
      wait_addr(3'd1, found);
      @(posedge CLK); #1 bus.DUMPREADY = 1'b0;
      @(posedge CLK);
      repeat (4) begin
         @(negedge CLK);
         checks++;
         if (bus.DUMPVALID !== 1'b1 || bus.DUMPDATA !== 8'h12 || bus.DUMPADDR !== 3'd2) begin
            errors++;
            $display("FAIL bp_hold got v=%0b d=%0h a=%0d exp v=1 d=12 a=2", bus.DUMPVALID, bus.DUMPDATA, bus.DUMPADDR);
         end
         @(posedge CLK);
      end
      #1 bus.DUMPREADY = 1'b1;
      wait_done(dbase, found);
      checks++;
      if (!found || b_addr.size() - base != 8) begin
         errors++;
         $display("FAIL bp_beats got %0d done=%0b exp 8 done=1", b_addr.size() - base, found);
      end
      for (int i = 0; i < 8; i++) begin
         if (base + i < b_addr.size()) begin
            checks++;
            if (b_addr[base+i] !== 3'(i) || b_data[base+i] !== 8'(8'h10 + i)) begin
               errors++;
               $display("FAIL bp_beat%0d got a=%0d d=%0h exp a=%0d d=%0h", i, b_addr[base+i], b_data[base+i], i, 8'h10 + i);
            end
         end
      end
   endtask

   task automatic test_write_between();
      int t, base, dbase;
      bit found;
      logic [7:0] exp_d;
      base  = b_addr.size();
      dbase = done_cnt;
      start_pulse(t);
      wait_addr(3'd3, found);
      @(posedge CLK); #1 rf[4] = 8'd95;
      wait_done(dbase, found);
      checks++;
      if (!found || b_addr.size() - base != 8) begin
         errors++;
         $display("FAIL wr_beats got %0d done=%0b exp 8 done=1", b_addr.size() - base, found);
      end
      for (int i = 0; i < 8; i++) begin
         exp_d = (i == 4) ? 8'd95 : 8'(8'h10 + i);
         if (base + i < b_addr.size()) begin
            checks++;
            if (b_addr[base+i] !== 3'(i) || b_data[base+i] !== exp_d) begin
               errors++;
               $display("FAIL wr_beat%0d got a=%0d d=%0h exp a=%0d d=%0h", i, b_addr[base+i], b_data[base+i], i, exp_d);
            end
         end
      end
      rf[4] = 8'h14;
   endtask

   task automatic test_abort();
      int t, base, dbase;
      bit found;
      base  = b_addr.size();
      dbase = done_cnt;
      start_pulse(t);
      wait_addr(3'd1, found);
      @(posedge CLK); #1;
      @(posedge CLK); #1 ABORT = 1'b1;
      @(posedge CLK); #1 ABORT = 1'b0;
      @(negedge CLK);
      checks++;
      if (bus.DUMPVALID !== 1'b0 || BUSY !== 1'b0 || bus.READREG1 !== 3'd0) begin
         errors++;
         $display("FAIL abort_idle got v=%0b b=%0b rr1=%0d exp 0 0 0", bus.DUMPVALID, BUSY, bus.READREG1);
      end
      repeat (4) @(negedge CLK);
      checks++;
      if (done_cnt != dbase || b_addr.size() - base != 2) begin
         errors++;
         $display("FAIL abort_nodone got done=%0d beats=%0d exp done=0 beats=2", done_cnt - dbase, b_addr.size() - base);
      end
      base  = b_addr.size();
      dbase = done_cnt;
      start_pulse(t);
      wait_done(dbase, found);
      checks++;
      if (!found || b_addr.size() - base != 8) begin
         errors++;
         $display("FAIL abort_restart got %0d done=%0b exp 8 done=1", b_addr.size() - base, found);
      end
      for (int i = 0; i < 8; i++) begin
         if (base + i < b_addr.size()) begin
            checks++;
            if (b_addr[base+i] !== 3'(i) || b_data[base+i] !== 8'(8'h10 + i)) begin
               errors++;
               $display("FAIL abort_beat%0d got a=%0d d=%0h exp a=%0d d=%0h", i, b_addr[base+i], b_data[base+i], i, 8'h10 + i);
            end
         end
      end
   endtask

   task automatic test_start_busy();
      int t, base, dbase;
      bit found;
      base  = b_addr.size();
      dbase = done_cnt;
      start_pulse(t);
      wait_addr(3'd1, found);
      START = 1'b1;
      @(posedge CLK); #1 START = 1'b0;
      wait_addr(3'd5, found);
      START = 1'b1;
      @(posedge CLK); #1 START = 1'b0;
      wait_done(dbase, found);
      repeat (8) @(negedge CLK);
      checks++;
      if (done_cnt - dbase != 1 || b_addr.size() - base != 8 || BUSY !== 1'b0) begin
         errors++;
         $display("FAIL busy_start got done=%0d beats=%0d busy=%0b exp 1 8 0", done_cnt - dbase, b_addr.size() - base, BUSY);
      end
   endtask

   task automatic test_reset_mid_dump();
      int t, base, dbase;
      bit found;
      start_pulse(t);
      wait_addr(3'd1, found);
      #2 RESET = 1'b0;
      #1;
      checks++;
      if ({bus.READREG1, bus.READREG2, bus.DUMPDATA, bus.DUMPADDR, bus.DUMPVALID, BUSY, DONE} !== 20'd0) begin
         errors++;
         $display("FAIL midreset_outputs got rr1=%0h rr2=%0h d=%0h a=%0h v=%0b b=%0b dn=%0b exp all 0",
                  bus.READREG1, bus.READREG2, bus.DUMPDATA, bus.DUMPADDR, bus.DUMPVALID, BUSY, DONE);
      end
      @(posedge CLK); #4 RESET = 1'b1;
      base  = b_addr.size();
      dbase = done_cnt;
      start_pulse(t);
      wait_done(dbase, found);
      checks++;
      if (!found || b_addr.size() - base != 8) begin
         errors++;
         $display("FAIL midreset_restart got %0d done=%0b exp 8 done=1", b_addr.size() - base, found);
      end
      for (int i = 0; i < 8; i++) begin
         if (base + i < b_addr.size()) begin
            checks++;
            if (b_addr[base+i] !== 3'(i) || b_data[base+i] !== 8'(8'h10 + i)) begin
               errors++;
               $display("FAIL midreset_beat%0d got a=%0d d=%0h exp a=%0d d=%0h", i, b_addr[base+i], b_data[base+i], i, 8'h10 + i);
            end
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) rf[i] = 8'(8'h10 + i);
      bus.DUMPREADY = 1'b1;
      test_reset();
      test_full_dump();
      test_backpressure();
      test_write_between();
      test_abort();
      test_start_busy();
      test_reset_mid_dump();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
